div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_pkg.sv | 27 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/div_arbiter.sv | 174 +++++++++++++++++
 tb/tb_div_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter.
// Contents:
//   ST_W / S_*     FSM state width and encodings. These are plain localparams
//                  so that older flows see stable state values.
//   WB_TIMEOUT     Number of cycles WAIT_BUSY waits for div_ready to drop
//                  before it assumes the divider has already finished.
//   WB_CNT_W       Width of the WAIT_BUSY cycle counter.
//   idx_w()        Width of a requester index for n requesters.
package div_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] S_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] S_ARB       = 3'd1;
  localparam logic [ST_W-1:0] S_START     = 3'd2;
  localparam logic [ST_W-1:0] S_WAIT_BUSY = 3'd3;
  localparam logic [ST_W-1:0] S_WAIT_DONE = 3'd4;
  localparam logic [ST_W-1:0] S_DONE      = 3'd5;

  localparam int WB_TIMEOUT = 2;
  localparam int WB_CNT_W   = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Starting at index ptr+1 and wrapping modulo NREQ, the first requester
// whose req bit is set wins.
// Ports:
//   req    in   NREQ  request vector
//   ptr    in   IW    index of the most recently served requester
//   gnt    out  NREQ  one-hot winner (all zero when no request is present)
//   idx    out  IW    winner index (0 when no request is present)
//   any    out  1     at least one request is present
module rr_pick
  import div_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    // Visit ptr+1 first and the current owner ptr last, so the owner only
    // wins again when nobody else is asking.
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[IW'(j)]) begin
        any          = 1'b1;
        gnt[IW'(j)]  = 1'b1;
        idx          = IW'(j);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one external divider among NREQ requesters.
// A round-robin winner is chosen in ARB, its operands are latched and driven
// to the divider, and the captured result is returned with a one-cycle done
// pulse to the winner. A zero divisor skips the divider and returns
// quotient = all ones, remainder = dividend, div0_err = 1.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req          in   NREQ      level requests, held until done[i]
//   dividend_in  in   NREQ*DIVW packed dividends, requester i at [i*DIVW +: DIVW]
//   divisor_in   in   NREQ*DIVW packed divisors, same packing
//   gnt          out  NREQ      one-hot pulse when operands are captured
//   done         out  NREQ      one-hot pulse when quotient/remainder are valid
//   quotient     out  DIVW      last result, held until the next done
//   remainder    out  DIVW      last result, held until the next done
//   div0_err     out  1         with done, the divisor was zero
//   busy         out  1         FSM is not IDLE
//   div_start    out  1         one-cycle start pulse to the divider
//   div_dividend out  DIVW      divider operand, stable for the whole run
//   div_divisor  out  DIVW      divider operand, stable for the whole run
//   div_ready    in   1         divider idle/finished (low while computing)
//   div_quotient in   DIVW      divider quotient result
//   div_remainder in  DIVW      divider remainder result
module div_arbiter
  import div_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DIVW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DIVW-1:0] dividend_in,
  input  logic [NREQ*DIVW-1:0] divisor_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DIVW-1:0]      quotient,
  output logic [DIVW-1:0]      remainder,
  output logic                 div0_err,
  output logic                 busy,
  output logic                 div_start,
  output logic [DIVW-1:0]      div_dividend,
  output logic [DIVW-1:0]      div_divisor,
  input  logic                 div_ready,
  input  logic [DIVW-1:0]      div_quotient,
  input  logic [DIVW-1:0]      div_remainder
);

  localparam int IW = idx_w(NREQ);

  logic [ST_W-1:0]     r_state;
  logic [ST_W-1:0]     w_state_nxt;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_idx;
  logic [DIVW-1:0]     r_dividend;
  logic [DIVW-1:0]     r_divisor;
  logic [DIVW-1:0]     r_quot;
  logic [DIVW-1:0]     r_rem;
  logic                r_div0;
  logic [WB_CNT_W-1:0] r_wb_cnt;

  logic [NREQ-1:0]     w_pick_gnt;
  logic [IW-1:0]       w_pick_idx;
  logic                w_pick_any;
  logic [DIVW-1:0]     w_sel_dividend;
  logic [DIVW-1:0]     w_sel_divisor;
  logic                w_sel_div0;
  logic [NREQ-1:0]     w_done;

  // Divide-by-zero saturates the quotient to the largest representable value.
  function automatic logic [DIVW-1:0] sat_quotient();
    return {DIVW{1'b1}};
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  // Operand mux driven by the one-hot pick.
  always_comb begin
    w_sel_dividend = '0;
    w_sel_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_sel_dividend = dividend_in[i*DIVW +: DIVW];
        w_sel_divisor  = divisor_in[i*DIVW +: DIVW];
      end
    end
  end

  assign w_sel_div0 = (w_sel_divisor == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if ((|req) && div_ready) w_state_nxt = S_ARB;
      // A request withdrawn between IDLE and ARB leaves nothing to grant.
      S_ARB:       if (!w_pick_any)     w_state_nxt = S_IDLE;
                   else if (w_sel_div0) w_state_nxt = S_DONE;
                   else                 w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_BUSY;
      // A divider that finishes before we see ready drop would otherwise
      // strand us here, so give up waiting after WB_TIMEOUT cycles.
      S_WAIT_BUSY: if (!div_ready || (r_wb_cnt == WB_CNT_W'(WB_TIMEOUT - 1)))
                     w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (div_ready) w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= IW'(NREQ - 1);
      r_idx      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div0     <= 1'b0;
      r_wb_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_ARB: begin
          if (w_pick_any) begin
            r_idx      <= w_pick_idx;
            r_ptr      <= w_pick_idx;
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
            r_div0     <= w_sel_div0;
            // Zero divisor: result is known now and presented in DONE.
            if (w_sel_div0) begin
              r_quot <= sat_quotient();
              r_rem  <= w_sel_dividend;
            end
          end
        end
        S_START:     r_wb_cnt <= '0;
        S_WAIT_BUSY: r_wb_cnt <= r_wb_cnt + 1'b1;
        S_WAIT_DONE: begin
          if (div_ready) begin
            r_quot <= div_quotient;
            r_rem  <= div_remainder;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_done = '0;
    if (r_state == S_DONE) w_done[r_idx] = 1'b1;
  end

  assign gnt          = (r_state == S_ARB) ? w_pick_gnt : '0;
  assign done         = w_done;
  assign quotient     = r_quot;
  assign remainder    = r_rem;
  assign div0_err     = (r_state == S_DONE) && r_div0;
  assign busy         = (r_state != S_IDLE);
  assign div_start    = (r_state == S_START);
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider and a
// transaction-level reference model of arbitration, latency and results.
module tb_div_arbiter;

  localparam int NREQ = 4;
  localparam int DIVW = 8;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*DIVW-1:0] dividend_in;
  logic [NREQ*DIVW-1:0] divisor_in;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [DIVW-1:0]      quotient;
  logic [DIVW-1:0]      remainder;
  logic                 div0_err;
  logic                 busy;
  logic                 div_start;
  logic [DIVW-1:0]      div_dividend;
  logic [DIVW-1:0]      div_divisor;
  logic                 div_ready;
  logic [DIVW-1:0]      div_quotient;
  logic [DIVW-1:0]      div_remainder;

  logic [DIVW-1:0] a [NREQ];
  logic [DIVW-1:0] b [NREQ];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // divider model controls
  int div_cycles = 4;
  bit fast       = 0;

  // monitor / model state
  bit              granted [NREQ];
  int              waitn   [NREQ];
  int              m_ptr;
  bit              inflight;
  int              f_idx, f_t, f_lat, f_starts;
  logic [DIVW-1:0] f_a, f_b;
  logic [DIVW-1:0] last_q, last_r;
  bit              prev_busy, prev_idle_req;

  int              d_idx [$];
  int              d_lat [$];
  int              d_st  [$];
  logic [DIVW-1:0] d_q   [$];
  logic [DIVW-1:0] d_r   [$];
  bit              d_e   [$];

  div_arbiter #(.NREQ(NREQ), .DIVW(DIVW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .dividend_in   (dividend_in),
    .divisor_in    (divisor_in),
    .gnt           (gnt),
    .done          (done),
    .quotient      (quotient),
    .remainder     (remainder),
    .div0_err      (div0_err),
    .busy          (busy),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_ready     (div_ready),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      dividend_in[i*DIVW +: DIVW] = a[i];
      divisor_in[i*DIVW +: DIVW]  = b[i];
    end
  end

  // Behavioural divider: either ready drops for div_cycles cycles after a
  // start, or (fast) the result appears immediately and ready stays high.
  logic [DIVW-1:0] dv_pq, dv_pr;
  int              dv_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_ready     <= 1'b1;
      div_quotient  <= '0;
      div_remainder <= '0;
      dv_cnt        <= 0;
    end else if (div_start) begin
      if (fast) begin
        div_quotient  <= (div_divisor == 0) ? 8'hEE : div_dividend / div_divisor;
        div_remainder <= (div_divisor == 0) ? 8'hEE : div_dividend % div_divisor;
      end else begin
        div_ready     <= 1'b0;
        dv_cnt        <= div_cycles - 1;
        dv_pq         <= (div_divisor == 0) ? 8'hEE : div_dividend / div_divisor;
        dv_pr         <= (div_divisor == 0) ? 8'hEE : div_dividend % div_divisor;
        div_quotient  <= 8'hA5;
        div_remainder <= 8'h5A;
      end
    end else if (!div_ready) begin
      if (dv_cnt == 0) begin
        div_ready     <= 1'b1;
        div_quotient  <= dv_pq;
        div_remainder <= dv_pr;
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first set request searching up from p+1, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Single compare process: every negedge, outputs against the model.
  initial begin : monitor
    int              e;
    logic [NREQ-1:0] ev;
    logic [DIVW-1:0] eq, er;
    m_ptr         = NREQ - 1;
    inflight      = 0;
    last_q        = '0;
    last_r        = '0;
    prev_busy     = 0;
    prev_idle_req = 0;
    for (int i = 0; i < NREQ; i++) begin granted[i] = 0; waitn[i] = 0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_start", div_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", div0_err, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_opa", div_dividend, 0);
        chk("rst_opb", div_divisor, 0);
        m_ptr = NREQ - 1;
        inflight = 0;
        last_q = '0;
        last_r = '0;
        for (int i = 0; i < NREQ; i++) begin granted[i] = 0; waitn[i] = 0; end
        prev_busy = 0;
        prev_idle_req = 0;
      end else begin
        if (prev_idle_req) chk("idle_to_arb", busy, 1);
        if (gnt != 0) begin
          chk("gnt_after_idle", prev_busy, 0);
          chk("gnt_not_inflight", inflight, 0);
          chk("gnt_busy", busy, 1);
          e  = model_pick(req, m_ptr);
          ev = '0;
          if (e >= 0) ev[e] = 1'b1;
          chk("gnt_vec", gnt, ev);
          if (e >= 0) begin
            for (int i = 0; i < NREQ; i++) begin
              if (i != e && req[i]) begin
                waitn[i]++;
                chk("fair_wait", waitn[i] <= NREQ - 1, 1);
              end
            end
            waitn[e]   = 0;
            inflight   = 1;
            f_idx      = e;
            f_a        = dividend_in[e*DIVW +: DIVW];
            f_b        = divisor_in[e*DIVW +: DIVW];
            f_t        = cyc;
            f_starts   = 0;
            f_lat      = (f_b == 0) ? 1 : (fast ? 5 : div_cycles + 3);
            m_ptr      = e;
            granted[e] = 1;
          end
        end
        if (div_start) begin
          chk("start_inflight", inflight, 1);
          chk("start_cycle", cyc, f_t + 1);
          f_starts++;
        end
        if (inflight && f_starts > 0) begin
          chk("opa_hold", div_dividend, f_a);
          chk("opb_hold", div_divisor, f_b);
        end
        if (done != 0) begin
          chk("done_inflight", inflight, 1);
          ev = '0;
          ev[f_idx] = 1'b1;
          chk("done_vec", done, ev);
          chk("done_lat", cyc - f_t, f_lat);
          eq = (f_b == 0) ? 8'hFF : f_a / f_b;
          er = (f_b == 0) ? f_a   : f_a % f_b;
          chk("done_quot", quotient, eq);
          chk("done_rem", remainder, er);
          chk("done_err", div0_err, (f_b == 0));
          chk("start_count", f_starts, (f_b != 0));
          d_idx.push_back(f_idx);
          d_lat.push_back(cyc - f_t);
          d_st.push_back(f_starts);
          d_q.push_back(quotient);
          d_r.push_back(remainder);
          d_e.push_back(div0_err);
          last_q = eq;
          last_r = er;
          inflight = 0;
          granted[f_idx] = 0;
          req[f_idx] = 1'b0;
        end else begin
          chk("quot_hold", quotient, last_q);
          chk("rem_hold", remainder, last_r);
          chk("err_low", div0_err, 0);
          if (inflight) begin
            chk("busy_inflight", busy, 1);
            chk("done_due", (cyc - f_t) < f_lat, 1);
            if ((cyc - f_t) >= f_lat) inflight = 0;
          end
        end
        for (int i = 0; i < NREQ; i++) if (!req[i]) waitn[i] = 0;
        prev_busy     = busy;
        prev_idle_req = !busy && (|req) && div_ready;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, input int maxc);
    int k = 0;
    while (d_idx.size() < n && k < maxc) begin
      tick(1);
      k++;
    end
    chk("wait_done_timeout", d_idx.size() >= n, 1);
  endtask

  task automatic clear_log();
    d_idx.delete(); d_lat.delete(); d_st.delete();
    d_q.delete();   d_r.delete();   d_e.delete();
  endtask

  function automatic logic [DIVW-1:0] rnd_op(input bit allow0);
    case ($urandom_range(0, 7))
      0:       return allow0 ? 8'd0 : 8'd1;
      1:       return 8'd255;
      2:       return 8'd1;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin : main
    int ca [4];
    int cb [4];
    int cq [4];
    int cr [4];
    int n0;
    int k;
    ca = '{200, 50, 9, 255};
    cb = '{3, 5, 4, 16};
    cq = '{66, 10, 2, 15};
    cr = '{2, 0, 1, 15};
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; b[i] = 8'd1; end
    tick(3);
    rst = 1'b0;
    tick(2);

    // Contention from reset: requester 0 has first priority.
    clear_log();
    div_cycles = 3;
    for (int i = 0; i < 4; i++) begin a[i] = 8'(ca[i]); b[i] = 8'(cb[i]); end
    req = 4'hF;
    wait_done(4, 200);
    if (d_idx.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("cont_order", d_idx[i], i);
        chk("cont_quot", d_q[i], cq[i]);
        chk("cont_rem", d_r[i], cr[i]);
      end
    end

    // Single request 100/7.
    clear_log();
    div_cycles = 4;
    a[0] = 8'd100; b[0] = 8'd7;
    req = 4'b0001;
    wait_done(1, 50);
    if (d_idx.size() >= 1) begin
      chk("single_idx", d_idx[0], 0);
      chk("single_quot", d_q[0], 14);
      chk("single_rem", d_r[0], 2);
      chk("single_err", d_e[0], 0);
      chk("single_starts", d_st[0], 1);
      chk("single_lat", d_lat[0], 7);
    end

    // Fairness: serve 1, then 0 and 1 together -> 0 first.
    clear_log();
    a[1] = 8'd20; b[1] = 8'd3;
    req = 4'b0010;
    wait_done(1, 50);
    a[0] = 8'd9; b[0] = 8'd2; a[1] = 8'd8; b[1] = 8'd8;
    req = 4'b0011;
    wait_done(3, 100);
    if (d_idx.size() >= 3) begin
      chk("fair_first", d_idx[0], 1);
      chk("fair_second", d_idx[1], 0);
      chk("fair_third", d_idx[2], 1);
      chk("fair_q0", d_q[1], 4);
      chk("fair_q1", d_q[2], 1);
    end

    // Divide by zero on requester 2.
    clear_log();
    a[2] = 8'd37; b[2] = 8'd0;
    req = 4'b0100;
    wait_done(1, 50);
    if (d_idx.size() >= 1) begin
      chk("div0_idx", d_idx[0], 2);
      chk("div0_quot", d_q[0], 8'hFF);
      chk("div0_rem", d_r[0], 37);
      chk("div0_err", d_e[0], 1);
      chk("div0_starts", d_st[0], 0);
      chk("div0_lat", d_lat[0], 1);
    end

    // Fast divider: ready never drops, WAIT_BUSY times out.
    clear_log();
    fast = 1;
    a[0] = 8'd200; b[0] = 8'd7;
    req = 4'b0001;
    wait_done(1, 50);
    if (d_idx.size() >= 1) begin
      chk("fast_quot", d_q[0], 28);
      chk("fast_rem", d_r[0], 4);
      chk("fast_lat", d_lat[0], 5);
    end
    fast = 0;

    // Reset in WAIT_DONE aborts without done; then re-request 81/9.
    clear_log();
    div_cycles = 10;
    a[0] = 8'd100; b[0] = 8'd3;
    req = 4'b0001;
    k = 0;
    while (!granted[0] && k < 20) begin tick(1); k++; end
    chk("abort_gnt_seen", granted[0], 1);
    n0 = d_idx.size();
    tick(6);
    rst = 1'b1;
    tick(2);
    req = '0;
    rst = 1'b0;
    tick(1);
    chk("abort_no_done", d_idx.size(), n0);
    chk("abort_busy", busy, 0);
    a[0] = 8'd81; b[0] = 8'd9;
    req = 4'b0001;
    wait_done(n0 + 1, 50);
    if (d_idx.size() >= n0 + 1) begin
      chk("rereq_quot", d_q[n0], 9);
      chk("rereq_rem", d_r[n0], 0);
    end

    // Randomized traffic.
    div_cycles = 3;
    for (int c = 0; c < 4000; c++) begin
      tick(1);
      if (!busy && !inflight && $urandom_range(0, 15) == 0) begin
        fast       = ($urandom_range(0, 3) == 0);
        div_cycles = $urandom_range(1, 6);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (granted[i]) begin
          if ($urandom_range(0, 3) == 0) begin a[i] = rnd_op(1); b[i] = rnd_op(1); end
          if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            a[i] = rnd_op(1);
            b[i] = rnd_op(1);
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
    end

    // Drain outstanding requests.
    k = 0;
    while ((req != 0 || busy) && k < 500) begin tick(1); k++; end
    chk("drain", (req == 0) && !busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
